// File: rtl/sd_emmc_controller_axi_wr_master_pkg.sv
// Shared constants for the eMMC card-to-memory AXI write master:
// burst geometry, AXI encodings and the FSM state type.
package sd_emmc_controller_axi_wr_master_pkg;

  localparam int unsigned AXI_BURST_LEN    = 16;
  localparam logic [2:0]  AXI_AWSIZE_4B    = 3'b010;
  localparam logic [1:0]  AXI_AWBURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_BRESP_OKAY   = 2'b00;

  // Bytes moved per burst; the DMA steps its address by this amount.
  localparam int unsigned BURST_BYTES  = 64;
  localparam int unsigned BURST_OFFS_W = $clog2(BURST_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } wr_state_e;

  // A burst start address must sit on a burst boundary.
  function automatic logic burst_misaligned(input logic [BURST_OFFS_W-1:0] offs);
    return (offs != {BURST_OFFS_W{1'b0}});
  endfunction

endpackage

// File: rtl/sd_emmc_controller_axi_wr_master.sv
// AXI4 write-burst master for the eMMC read-from-card DMA path.
// Turns DMA address/data handshakes into fixed-length INCR bursts,
// one beat at a time, and collects B-channel / alignment errors.
module sd_emmc_controller_axi_wr_master
  import sd_emmc_controller_axi_wr_master_pkg::*;
#(
  parameter int unsigned C_BURST_LEN = AXI_BURST_LEN,
  parameter int unsigned C_ADDR_W    = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [C_ADDR_W-1:0] write_addr,
  input  logic                addr_write_valid,
  output logic                addr_write_ready,
  input  logic                data_write_valid,
  output logic                next_data_word,
  output logic                w_last,
  input  logic [31:0]         fifo_rd_data,
  input  logic                abort,
  input  logic                dat_int_rst,
  output logic [1:0]          wr_error,
  output logic                busy,
  output logic [C_ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [31:0]         m_axi_wdata,
  output logic [3:0]          m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready
);

  localparam logic [7:0] AWLEN     = 8'(C_BURST_LEN - 1);
  localparam logic [3:0] LAST_BEAT = 4'(C_BURST_LEN - 1);

  wr_state_e           state_q, state_d;
  logic [C_ADDR_W-1:0] awaddr_q, awaddr_d;
  logic                awvalid_q, awvalid_d;
  logic                addr_write_ready_q, addr_write_ready_d;
  logic [3:0]          beat_q, beat_d;
  logic                wvalid_q, wvalid_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic                wlast_q, wlast_d;
  logic                next_data_word_q, next_data_word_d;
  logic                w_last_q, w_last_d;
  logic                drain_q, drain_d;
  logic                bready_q, bready_d;
  logic [1:0]          wr_error_q, wr_error_d;
  logic                busy_q, busy_d;
  logic [1:0]          err_set;
  logic                drain_now;

  // Next-state and next-output computation for the burst FSM.
  always_comb begin
    state_d            = state_q;
    awaddr_d           = awaddr_q;
    awvalid_d          = awvalid_q;
    addr_write_ready_d = 1'b0;
    beat_d             = beat_q;
    wvalid_d           = wvalid_q;
    wdata_d            = wdata_q;
    wstrb_d            = wstrb_q;
    wlast_d            = wlast_q;
    next_data_word_d   = 1'b0;
    w_last_d           = w_last_q;
    drain_d            = drain_q;
    bready_d           = bready_q;
    err_set            = 2'b00;
    // An abort takes effect in the very cycle it arrives.
    drain_now          = drain_q | abort;

    case (state_q)
      ST_IDLE: begin
        if (addr_write_valid) begin
          awaddr_d   = write_addr;
          awvalid_d  = 1'b1;
          w_last_d   = 1'b0;
          drain_d    = 1'b0;
          err_set[1] = burst_misaligned(write_addr[BURST_OFFS_W-1:0]);
          state_d    = ST_AW;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_AW: begin
        drain_d = drain_now;
        if (awvalid_q && m_axi_awready) begin
          awvalid_d          = 1'b0;
          addr_write_ready_d = 1'b1;
          beat_d             = 4'd0;
          state_d            = ST_W;
        end else begin
          state_d = ST_AW;
        end
      end

      ST_W: begin
        drain_d = drain_now;
        if (wvalid_q) begin
          if (m_axi_wready) begin
            wvalid_d         = 1'b0;
            wlast_d          = 1'b0;
            next_data_word_d = ~drain_now;
            beat_d           = beat_q + 4'd1;
            if (wlast_q) begin
              w_last_d = 1'b1;
              bready_d = 1'b1;
              state_d  = ST_B;
            end else begin
              state_d = ST_W;
            end
          end else begin
            wvalid_d = 1'b1;
          end
        end else if (data_write_valid || drain_now) begin
          wvalid_d = 1'b1;
          wlast_d  = (beat_q == LAST_BEAT);
          if (drain_now) begin
            wdata_d = 32'h0000_0000;
            wstrb_d = 4'h0;
          end else begin
            wdata_d = fifo_rd_data;
            wstrb_d = 4'hF;
          end
        end else begin
          wvalid_d = 1'b0;
        end
      end

      ST_B: begin
        if (m_axi_bvalid) begin
          bready_d   = 1'b0;
          drain_d    = 1'b0;
          err_set[0] = (m_axi_bresp != AXI_BRESP_OKAY);
          state_d    = ST_IDLE;
        end else begin
          bready_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new error event in the clearing cycle is kept.
    wr_error_d = (dat_int_rst ? 2'b00 : wr_error_q) | err_set;
    busy_d     = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q            <= ST_IDLE;
      awaddr_q           <= {C_ADDR_W{1'b0}};
      awvalid_q          <= 1'b0;
      addr_write_ready_q <= 1'b0;
      beat_q             <= 4'd0;
      wvalid_q           <= 1'b0;
      wdata_q            <= 32'h0000_0000;
      wstrb_q            <= 4'h0;
      wlast_q            <= 1'b0;
      next_data_word_q   <= 1'b0;
      w_last_q           <= 1'b0;
      drain_q            <= 1'b0;
      bready_q           <= 1'b0;
      wr_error_q         <= 2'b00;
      busy_q             <= 1'b0;
    end else begin
      state_q            <= state_d;
      awaddr_q           <= awaddr_d;
      awvalid_q          <= awvalid_d;
      addr_write_ready_q <= addr_write_ready_d;
      beat_q             <= beat_d;
      wvalid_q           <= wvalid_d;
      wdata_q            <= wdata_d;
      wstrb_q            <= wstrb_d;
      wlast_q            <= wlast_d;
      next_data_word_q   <= next_data_word_d;
      w_last_q           <= w_last_d;
      drain_q            <= drain_d;
      bready_q           <= bready_d;
      wr_error_q         <= wr_error_d;
      busy_q             <= busy_d;
    end
  end

  assign addr_write_ready = addr_write_ready_q;
  assign next_data_word   = next_data_word_q;
  assign w_last           = w_last_q;
  assign wr_error         = wr_error_q;
  assign busy             = busy_q;
  assign m_axi_awaddr     = awaddr_q;
  assign m_axi_awlen      = AWLEN;
  assign m_axi_awsize     = AXI_AWSIZE_4B;
  assign m_axi_awburst    = AXI_AWBURST_INCR;
  assign m_axi_awvalid    = awvalid_q;
  assign m_axi_wdata      = wdata_q;
  assign m_axi_wstrb      = wstrb_q;
  assign m_axi_wlast      = wlast_q;
  assign m_axi_wvalid     = wvalid_q;
  assign m_axi_bready     = bready_q;

endmodule

// File: tb/tb_sd_emmc_controller_axi_wr_master.sv
// Directed bench for the eMMC AXI write master: a small DMA/FIFO model
// drives bursts while the bench plays the AXI slave.
module tb_sd_emmc_controller_axi_wr_master;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] write_addr = 32'h0;
  logic        addr_write_valid = 1'b0;
  logic        addr_write_ready;
  logic        data_write_valid = 1'b0;
  logic        next_data_word;
  logic        w_last;
  logic [31:0] fifo_rd_data = 32'h0;
  logic        abort = 1'b0;
  logic        dat_int_rst = 1'b0;
  logic [1:0]  wr_error;
  logic        busy;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;

  always #5 clock = ~clock;

  sd_emmc_controller_axi_wr_master #(.C_BURST_LEN(16), .C_ADDR_W(32)) dut (
    .clock(clock), .reset(reset),
    .write_addr(write_addr), .addr_write_valid(addr_write_valid),
    .addr_write_ready(addr_write_ready), .data_write_valid(data_write_valid),
    .next_data_word(next_data_word), .w_last(w_last),
    .fifo_rd_data(fifo_rd_data), .abort(abort), .dat_int_rst(dat_int_rst),
    .wr_error(wr_error), .busy(busy),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  int total = 0;
  int bad   = 0;

  // Observations from the most recent burst.
  int          n_beats, n_ndw, n_awr, fifo_idx, first_idx;
  logic [31:0] beat_data [32];
  logic [3:0]  beat_strb [32];
  logic [31:0] wlast_mask;
  logic [31:0] obs_awaddr;
  logic [7:0]  obs_awlen;
  logic [2:0]  obs_awsize;
  logic [1:0]  obs_awburst;
  logic        w_last_after, busy_after, w_last_at_aw, timed_out;

  function automatic logic [31:0] fifo_word(input int k);
    return 32'hD00D_0000 | 32'(k);
  endfunction

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic do_burst(input logic [31:0] addr, input int aw_delay, input int wr_pct,
                          input int abort_at, input logic [1:0] resp, input logic clr_with_b);
    int          aw_wait;
    logic        b_sent, aborted, done, aw_pend, w_pend;
    logic [31:0] p_awaddr, p_wdata;
    logic [3:0]  p_wstrb;
    logic        p_wlast;
    n_beats = 0; n_ndw = 0; n_awr = 0; wlast_mask = 32'h0; timed_out = 1'b0;
    aw_wait = 0; b_sent = 1'b0; aborted = 1'b0; done = 1'b0;
    aw_pend = 1'b0; w_pend = 1'b0; w_last_at_aw = 1'bx;
    p_awaddr = 32'h0; p_wdata = 32'h0; p_wstrb = 4'h0; p_wlast = 1'b0;
    first_idx = fifo_idx;
    fifo_rd_data = fifo_word(fifo_idx);
    write_addr = addr;
    addr_write_valid = 1'b1;
    data_write_valid = 1'b1;
    step;
    addr_write_valid = 1'b0;
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      if (b_sent) begin
        m_axi_bvalid = 1'b0;
        dat_int_rst  = 1'b0;
        w_last_after = w_last;
        busy_after   = busy;
        done         = 1'b1;
      end else begin
        if (aw_pend) begin
          total++;
          if (m_axi_awvalid !== 1'b1 || m_axi_awaddr !== p_awaddr) begin
            bad++;
            $display("FAIL aw_stable: awvalid=%b awaddr=%h, required 1 %h", m_axi_awvalid, m_axi_awaddr, p_awaddr);
          end
        end
        if (w_pend) begin
          total++;
          if (m_axi_wvalid !== 1'b1 || m_axi_wdata !== p_wdata || m_axi_wstrb !== p_wstrb || m_axi_wlast !== p_wlast) begin
            bad++;
            $display("FAIL w_stable: wvalid=%b wdata=%h wstrb=%h wlast=%b, required 1 %h %h %b",
                     m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, p_wdata, p_wstrb, p_wlast);
          end
        end
        if (m_axi_awvalid) begin
          if (aw_wait == 0) w_last_at_aw = w_last;
          obs_awaddr = m_axi_awaddr; obs_awlen = m_axi_awlen;
          obs_awsize = m_axi_awsize; obs_awburst = m_axi_awburst;
          m_axi_awready = (aw_wait >= aw_delay);
          aw_wait++;
        end else begin
          m_axi_awready = 1'b0;
        end
        aw_pend = m_axi_awvalid && !m_axi_awready;
        p_awaddr = m_axi_awaddr;
        if (m_axi_wvalid) begin
          m_axi_wready = (wr_pct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < wr_pct);
          if (m_axi_wready && n_beats < 32) begin
            beat_data[n_beats] = m_axi_wdata;
            beat_strb[n_beats] = m_axi_wstrb;
            if (m_axi_wlast) wlast_mask[n_beats] = 1'b1;
          end
          if (m_axi_wready) n_beats++;
        end else begin
          m_axi_wready = 1'b0;
        end
        w_pend = m_axi_wvalid && !m_axi_wready;
        p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb; p_wlast = m_axi_wlast;
        if (addr_write_ready) n_awr++;
        if (next_data_word) begin
          n_ndw++;
          fifo_idx++;
          fifo_rd_data = fifo_word(fifo_idx);
          if (abort_at >= 0 && !aborted && n_ndw == abort_at) begin
            abort = 1'b1;
            aborted = 1'b1;
          end else begin
            abort = 1'b0;
          end
        end else begin
          abort = 1'b0;
        end
        if (m_axi_bready) begin
          m_axi_bvalid = 1'b1;
          m_axi_bresp  = resp;
          dat_int_rst  = clr_with_b;
          b_sent       = 1'b1;
        end else begin
          m_axi_bvalid = 1'b0;
        end
        step;
      end
    end
    if (!done) timed_out = 1'b1;
    data_write_valid = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00; abort = 1'b0; dat_int_rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [77:0] outs;
    reset = 1'b0;
    repeat (3) step;
    outs = {addr_write_ready, next_data_word, w_last, wr_error, busy, m_axi_awaddr, m_axi_awvalid,
            m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready};
    total++;
    if (outs !== 78'h0) begin bad++; $display("FAIL reset_outs: got %h, required 0", outs); end
    total++;
    if (m_axi_awlen !== 8'd15 || m_axi_awsize !== 3'b010 || m_axi_awburst !== 2'b01) begin
      bad++; $display("FAIL reset_consts: awlen=%0d awsize=%b awburst=%b, required 15 010 01", m_axi_awlen, m_axi_awsize, m_axi_awburst);
    end
    reset = 1'b1;
    step;
  endtask

  task automatic test_single_burst;
    do_burst(32'h1000_0000, 0, 100, -1, 2'b00, 1'b0);
    total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL single_timeout: burst did not finish"); end
    total++; if (obs_awaddr !== 32'h1000_0000) begin bad++; $display("FAIL single_awaddr: got %h, required 10000000", obs_awaddr); end
    total++;
    if (obs_awlen !== 8'd15 || obs_awsize !== 3'b010 || obs_awburst !== 2'b01) begin
      bad++; $display("FAIL single_awattr: awlen=%0d awsize=%b awburst=%b, required 15 010 01", obs_awlen, obs_awsize, obs_awburst);
    end
    total++; if (n_beats !== 16) begin bad++; $display("FAIL single_beats: got %0d, required 16", n_beats); end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (beat_data[i] !== fifo_word(first_idx + i) || beat_strb[i] !== 4'hF) begin
        bad++; $display("FAIL single_beat%0d: data=%h strb=%h, required %h F", i, beat_data[i], beat_strb[i], fifo_word(first_idx + i));
      end
    end
    total++; if (wlast_mask !== 32'h0000_8000) begin bad++; $display("FAIL single_wlast: mask=%h, required 00008000", wlast_mask); end
    total++; if (n_ndw !== 16) begin bad++; $display("FAIL single_ndw: got %0d, required 16", n_ndw); end
    total++; if (n_awr !== 1) begin bad++; $display("FAIL single_awready_pulse: got %0d cycles, required 1", n_awr); end
    total++; if (w_last_after !== 1'b1) begin bad++; $display("FAIL single_w_last: got %b, required 1", w_last_after); end
    total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL single_busy: got %b, required 0", busy_after); end
    total++; if (wr_error !== 2'b00) begin bad++; $display("FAIL single_err: got %b, required 00", wr_error); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [2];
    addrs[0] = 32'h2000_0000;
    addrs[1] = 32'h2000_0040;
    for (int b = 0; b < 2; b++) begin
      do_burst(addrs[b], 5, 50, -1, 2'b00, 1'b0);
      total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL b2b%0d_timeout: burst did not finish", b); end
      total++; if (obs_awaddr !== addrs[b]) begin bad++; $display("FAIL b2b%0d_awaddr: got %h, required %h", b, obs_awaddr, addrs[b]); end
      total++; if (n_beats !== 16 || n_ndw !== 16) begin bad++; $display("FAIL b2b%0d_count: beats=%0d ndw=%0d, required 16 16", b, n_beats, n_ndw); end
      total++; if (w_last_at_aw !== 1'b0) begin bad++; $display("FAIL b2b%0d_w_last_clear: got %b, required 0", b, w_last_at_aw); end
      for (int i = 0; i < 16; i++) begin
        total++;
        if (beat_data[i] !== fifo_word(first_idx + i)) begin
          bad++; $display("FAIL b2b%0d_beat%0d: data=%h, required %h", b, i, beat_data[i], fifo_word(first_idx + i));
        end
      end
      total++; if (wlast_mask !== 32'h0000_8000) begin bad++; $display("FAIL b2b%0d_wlast: mask=%h, required 00008000", b, wlast_mask); end
    end
  endtask

  task automatic test_bresp_error;
    do_burst(32'h1000_0040, 0, 100, -1, 2'b10, 1'b0);
    total++; if (wr_error !== 2'b01) begin bad++; $display("FAIL bresp_set: got %b, required 01", wr_error); end
    dat_int_rst = 1'b1; step; dat_int_rst = 1'b0;
    total++; if (wr_error !== 2'b00) begin bad++; $display("FAIL bresp_clear: got %b, required 00", wr_error); end
    do_burst(32'h1000_0080, 0, 100, -1, 2'b10, 1'b1);
    total++; if (wr_error !== 2'b01) begin bad++; $display("FAIL bresp_set_wins: got %b, required 01", wr_error); end
    dat_int_rst = 1'b1; step; dat_int_rst = 1'b0;
    total++; if (wr_error !== 2'b00) begin bad++; $display("FAIL bresp_clear2: got %b, required 00", wr_error); end
  endtask

  task automatic test_misaligned;
    do_burst(32'h1000_0004, 0, 100, -1, 2'b00, 1'b0);
    total++; if (obs_awaddr !== 32'h1000_0004) begin bad++; $display("FAIL misal_awaddr: got %h, required 10000004", obs_awaddr); end
    total++; if (n_beats !== 16) begin bad++; $display("FAIL misal_beats: got %0d, required 16", n_beats); end
    total++; if (wr_error !== 2'b10) begin bad++; $display("FAIL misal_err: got %b, required 10", wr_error); end
    dat_int_rst = 1'b1; step; dat_int_rst = 1'b0;
    total++; if (wr_error !== 2'b00) begin bad++; $display("FAIL misal_clear: got %b, required 00", wr_error); end
  endtask

  task automatic test_abort;
    logic [31:0] exp_d;
    logic [3:0]  exp_s;
    do_burst(32'h1000_0100, 0, 100, 5, 2'b00, 1'b0);
    total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL abort_timeout: burst did not finish"); end
    total++; if (n_beats !== 16) begin bad++; $display("FAIL abort_beats: got %0d, required 16", n_beats); end
    total++; if (n_ndw !== 5) begin bad++; $display("FAIL abort_ndw: got %0d, required 5", n_ndw); end
    for (int i = 0; i < 16; i++) begin
      exp_d = (i < 5) ? fifo_word(first_idx + i) : 32'h0;
      exp_s = (i < 5) ? 4'hF : 4'h0;
      total++;
      if (beat_data[i] !== exp_d || beat_strb[i] !== exp_s) begin
        bad++; $display("FAIL abort_beat%0d: data=%h strb=%h, required %h %h", i, beat_data[i], beat_strb[i], exp_d, exp_s);
      end
    end
    total++; if (wlast_mask !== 32'h0000_8000) begin bad++; $display("FAIL abort_wlast: mask=%h, required 00008000", wlast_mask); end
    total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b, required 0", busy_after); end
  endtask

  task automatic test_reset_mid_burst;
    logic [77:0] outs;
    int          hs;
    logic        found;
    hs = 0; found = 1'b0;
    fifo_rd_data = fifo_word(fifo_idx);
    write_addr = 32'h3000_0008;
    addr_write_valid = 1'b1;
    data_write_valid = 1'b1;
    step;
    addr_write_valid = 1'b0;
    m_axi_awready = 1'b1;
    for (int cyc = 0; cyc < 200 && !found; cyc++) begin
      if (m_axi_wvalid && hs == 8) begin
        found = 1'b1;
      end else begin
        if (next_data_word) begin fifo_idx++; fifo_rd_data = fifo_word(fifo_idx); end
        m_axi_wready = m_axi_wvalid;
        if (m_axi_wvalid) hs++;
        step;
      end
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL rstmid_reach: beat 9 never presented"); end
    reset = 1'b0; m_axi_wready = 1'b0; m_axi_awready = 1'b0; data_write_valid = 1'b0;
    step;
    outs = {addr_write_ready, next_data_word, w_last, wr_error, busy, m_axi_awaddr, m_axi_awvalid,
            m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready};
    total++; if (outs !== 78'h0) begin bad++; $display("FAIL rstmid_outs: got %h, required 0", outs); end
    reset = 1'b1;
    step;
    do_burst(32'h3000_0040, 0, 100, -1, 2'b00, 1'b0);
    total++; if (n_beats !== 16 || n_ndw !== 16) begin bad++; $display("FAIL rstmid_after: beats=%0d ndw=%0d, required 16 16", n_beats, n_ndw); end
    total++; if (beat_data[15] !== fifo_word(first_idx + 15)) begin bad++; $display("FAIL rstmid_data: got %h, required %h", beat_data[15], fifo_word(first_idx + 15)); end
    total++; if (wr_error !== 2'b00 || busy_after !== 1'b0) begin bad++; $display("FAIL rstmid_status: err=%b busy=%b, required 00 0", wr_error, busy_after); end
  endtask

  initial begin
    fifo_idx = 0;
    test_reset;
    test_single_burst;
    test_back_to_back;
    test_bresp_error;
    test_misaligned;
    test_abort;
    test_reset_mid_burst;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
